// File: rtl/stft_det_pkg.sv
// Shared definitions for the STFT per-bin threshold detector.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package stft_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WN = 10;   // ROM address / bin-index width
    localparam int DEF_WL = 10;   // ROM threshold word width
    localparam int DEF_WD = 16;   // magnitude width

    // Width both compare operands are zero-extended to.
    function automatic int cmp_width(input int wd, input int wth);
        return (wd > wth) ? wd : wth;
    endfunction

endpackage

// File: rtl/stft_det_outreg.sv
// Single-stage valid/ready pipeline register carrying {det, bin, mag}.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds its contents while out_valid & ~out_ready; the parent only loads when empty or draining.
// Ports: load/load_* capture a beat, flush drops any pending beat, out_* is the registered stream.
module stft_det_outreg #(
    parameter int WN = 10,
    parameter int WD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          load_det,
    input  logic [WN-1:0] load_bin,
    input  logic [WD-1:0] load_mag,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          out_det,
    output logic [WN-1:0] out_bin,
    output logic [WD-1:0] out_mag
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_det   <= 1'b0;
            out_bin   <= '0;
            out_mag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_det   <= load_det;
            out_bin   <= load_bin;
            out_mag   <= load_mag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stft_th_detector.sv
// Per-bin threshold detector: compares each STFT magnitude with the scaled ROM threshold, counts hits per frame.
// Latency: 1 cycle from accepted input beat to out_*; frame_done one cycle after the last beat drains.
// Backpressure: in_ready = RUN & (~out_valid | out_ready); full throughput, beats held while out_ready is low.
// Ports: start/abort control, in_* magnitude stream, TH_addr/oTH to the external threshold ROM (combinational read),
//        out_* detection stream, frame_done/hit_cnt frame summary, busy.
// Optional: define STFT_TH_PEAK_HOLD_EN to add peak_bin/peak_mag (frame maximum, earliest bin on ties).
module stft_th_detector
    import stft_det_pkg::*;
#(
    parameter int WN       = DEF_WN,
    parameter int WL       = DEF_WL,
    parameter int WD       = DEF_WD,
    parameter int NBINS    = 512,
    parameter int TH_SHIFT = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [WD-1:0] in_mag,
    output logic          in_ready,
    output logic [WN-1:0] TH_addr,
    input  logic [WL-1:0] oTH,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_det,
    output logic [WN-1:0] out_bin,
    output logic [WD-1:0] out_mag,
    output logic          frame_done,
    output logic [WN:0]   hit_cnt,
`ifdef STFT_TH_PEAK_HOLD_EN
    output logic [WN-1:0] peak_bin,
    output logic [WD-1:0] peak_mag,
`endif
    output logic          busy
);

    localparam int            CW       = cmp_width(WD, WL + TH_SHIFT);
    localparam logic [WN-1:0] LAST_BIN = WN'(NBINS - 1);

    state_t        state;
    logic [WN-1:0] bin_cnt;
    logic [WN:0]   hit_acc;
    logic [CW-1:0] mag_ext;
    logic [CW-1:0] th_ext;
    logic          det;
    logic          accept;

    // Shift after widening so no threshold bits are lost.
    assign mag_ext  = CW'(in_mag);
    assign th_ext   = CW'(oTH) << TH_SHIFT;
    assign det      = (mag_ext >= th_ext);

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign TH_addr  = bin_cnt;
    assign busy     = (state != IDLE);

`ifdef STFT_TH_PEAK_HOLD_EN
    logic [WN-1:0] run_peak_bin;
    logic [WD-1:0] run_peak_mag;

    // Strict '>' keeps the earliest bin on equal maxima.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_peak_bin <= '0;
            run_peak_mag <= '0;
            peak_bin     <= '0;
            peak_mag     <= '0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                run_peak_bin <= '0;
                run_peak_mag <= '0;
                peak_bin     <= '0;
                peak_mag     <= '0;
            end else if (accept && in_mag > run_peak_mag) begin
                run_peak_bin <= bin_cnt;
                run_peak_mag <= in_mag;
            end else if (state == DONE && (!out_valid || out_ready)) begin
                peak_bin <= run_peak_bin;
                peak_mag <= run_peak_mag;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bin_cnt    <= '0;
            hit_acc    <= '0;
            hit_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (abort) begin
            // Pending beat is dropped by the output register's flush.
            state      <= IDLE;
            bin_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        bin_cnt <= '0;
                        hit_acc <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (det) begin
                            hit_acc <= hit_acc + 1'b1;
                        end
                        if (bin_cnt == LAST_BIN) begin
                            bin_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bin_cnt <= bin_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Wait for the last detection beat to leave before reporting.
                    if (!out_valid || out_ready) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        hit_cnt    <= hit_acc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stft_det_outreg #(
        .WN (WN),
        .WD (WD)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .load      (accept),
        .load_det  (det),
        .load_bin  (bin_cnt),
        .load_mag  (in_mag),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_det   (out_det),
        .out_bin   (out_bin),
        .out_mag   (out_mag)
    );

endmodule

// File: tb/tb_stft_th_detector.sv
// Directed bench for stft_th_detector with NBINS=8 and a constant ROM word of 2 (threshold 128).
// Latency: n/a.
// Backpressure: exercised through out_ready.
module tb_stft_th_detector;

    localparam int WN       = 10;
    localparam int WL       = 10;
    localparam int WD       = 16;
    localparam int NBINS    = 8;
    localparam int TH_SHIFT = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [WD-1:0] in_mag;
    logic          in_ready;
    logic [WN-1:0] TH_addr;
    logic [WL-1:0] oTH;
    logic          out_valid;
    logic          out_ready;
    logic          out_det;
    logic [WN-1:0] out_bin;
    logic [WD-1:0] out_mag;
    logic          frame_done;
    logic [WN:0]   hit_cnt;
    logic          busy;
`ifdef STFT_TH_PEAK_HOLD_EN
    logic [WN-1:0] peak_bin;
    logic [WD-1:0] peak_mag;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Constant-word threshold ROM.
    assign oTH = 10'd2;

    stft_th_detector #(
        .WN       (WN),
        .WL       (WL),
        .WD       (WD),
        .NBINS    (NBINS),
        .TH_SHIFT (TH_SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_mag     (in_mag),
        .in_ready   (in_ready),
        .TH_addr    (TH_addr),
        .oTH        (oTH),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_det    (out_det),
        .out_bin    (out_bin),
        .out_mag    (out_mag),
        .frame_done (frame_done),
        .hit_cnt    (hit_cnt),
`ifdef STFT_TH_PEAK_HOLD_EN
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ref_v);
        n_chk++;
        assert (obs === ref_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, ref_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat with out_ready high; checks address before and output after the edge.
    task automatic beat(input logic [15:0] m, input logic [9:0] b, input logic d);
        in_valid  = 1'b1;
        in_mag    = m;
        out_ready = 1'b1;
        #1;
        chk("in_ready", 32'(in_ready), 32'd1);
        chk("th_addr", 32'(TH_addr), 32'(b));
        tick();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_bin", 32'(out_bin), 32'(b));
        chk("out_det", 32'(out_det), 32'(d));
        chk("out_mag", 32'(out_mag), 32'(m));
        in_valid = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_addr", 32'(TH_addr), 32'd0);
    endtask

    task automatic finish_frame(input int hits);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_wrap_addr", 32'(TH_addr), 32'd0);
        chk("done_no_pulse", 32'(frame_done), 32'd0);
        tick();
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("hit_cnt", 32'(hit_cnt), 32'(hits));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("drained", 32'(out_valid), 32'd0);
        tick();
        chk("frame_done_1cyc", 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_mag    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_addr", 32'(TH_addr), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic frame: threshold 128, hits at 128,129,500,128,65535.
        start_frame();
        beat(16'd0,     10'd0, 1'b0);
        beat(16'd127,   10'd1, 1'b0);
        beat(16'd128,   10'd2, 1'b1);
        beat(16'd129,   10'd3, 1'b1);
        beat(16'd500,   10'd4, 1'b1);
        beat(16'd1,     10'd5, 1'b0);
        beat(16'd128,   10'd6, 1'b1);
        beat(16'd65535, 10'd7, 1'b1);
        finish_frame(5);
`ifdef STFT_TH_PEAK_HOLD_EN
        chk("peak_mag_a", 32'(peak_mag), 32'd65535);
        chk("peak_bin_a", 32'(peak_bin), 32'd7);
`endif

        // Backpressure after bin 2, then last-beat drain; bin 6 is 127 so 4 hits.
        start_frame();
        beat(16'd0,   10'd0, 1'b0);
        beat(16'd127, 10'd1, 1'b0);
        beat(16'd128, 10'd2, 1'b1);
        in_valid  = 1'b1;
        in_mag    = 16'd129;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_bin", 32'(out_bin), 32'd2);
            chk("bp_out_mag", 32'(out_mag), 32'd128);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_addr", 32'(TH_addr), 32'd3);
        end
        beat(16'd129, 10'd3, 1'b1);
        beat(16'd500, 10'd4, 1'b1);
        beat(16'd1,   10'd5, 1'b0);
        beat(16'd127, 10'd6, 1'b0);
        beat(16'd65535, 10'd7, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("drain_hold_bin", 32'(out_bin), 32'd7);
            chk("drain_hold_valid", 32'(out_valid), 32'd1);
            chk("drain_no_pulse", 32'(frame_done), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("drain_frame_done", 32'(frame_done), 32'd1);
        chk("drain_hit_cnt", 32'(hit_cnt), 32'd4);
        chk("drain_idle", 32'(busy), 32'd0);
        tick();
        chk("drain_pulse_end", 32'(frame_done), 32'd0);

        // Abort at bin 4 with a beat pending.
        start_frame();
        beat(16'd200,  10'd0, 1'b1);
        beat(16'd0,    10'd1, 1'b0);
        beat(16'd300,  10'd2, 1'b1);
        beat(16'd300,  10'd3, 1'b1);
        beat(16'd1000, 10'd4, 1'b1);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_mag   = 16'd999;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_no_done", 32'(frame_done), 32'd0);
        chk("abort_hit_cnt", 32'(hit_cnt), 32'd4);
        chk("abort_addr", 32'(TH_addr), 32'd0);
        tick();
        chk("abort_no_done2", 32'(frame_done), 32'd0);
        chk("abort_hit_cnt2", 32'(hit_cnt), 32'd4);

        // start together with abort stays idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);

        // start mid-RUN ignored; equal maxima keep bin 1; 3 hits.
        start_frame();
`ifdef STFT_TH_PEAK_HOLD_EN
        chk("peak_clr_mag", 32'(peak_mag), 32'd0);
        chk("peak_clr_bin", 32'(peak_bin), 32'd0);
`endif
        beat(16'd5,   10'd0, 1'b0);
        beat(16'd300, 10'd1, 1'b1);
        start = 1'b1;
        beat(16'd300, 10'd2, 1'b1);
        start = 1'b0;
        beat(16'd10,  10'd3, 1'b0);
        beat(16'd300, 10'd4, 1'b1);
        beat(16'd0,   10'd5, 1'b0);
        beat(16'd0,   10'd6, 1'b0);
        beat(16'd64,  10'd7, 1'b0);
        finish_frame(3);
`ifdef STFT_TH_PEAK_HOLD_EN
        chk("peak_mag_tie", 32'(peak_mag), 32'd300);
        chk("peak_bin_tie", 32'(peak_bin), 32'd1);
`endif

        // Asynchronous reset mid-frame, asserted away from any clock edge.
        start_frame();
        beat(16'd128, 10'd0, 1'b1);
        beat(16'd129, 10'd1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_bin", 32'(out_bin), 32'd0);
        chk("arst_out_mag", 32'(out_mag), 32'd0);
        chk("arst_out_det", 32'(out_det), 32'd0);
        chk("arst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("arst_addr", 32'(TH_addr), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
